// File: rtl/imem_loader.sv
// Instruction SRAM writer: unpacks a length-prefixed big-endian byte stream into
// 32-bit SRAM writes and holds the CPU until the image is complete.
//
// Ports:
//   clk, reset_n (async, active low)
//   start          pulse, begins a load from IDLE/DONE/ERR
//   in_data/in_valid/in_ready  byte stream, transfer = in_valid & in_ready
//   mem_cs/mem_oe/mem_we/mem_addr/mem_din  SRAM write port
//   cpu_hold       holds the pipeline until DONE
//   done/err       load outcome levels
//   words_written  words committed this load
//
// Optional build macro: IMEM_LOADER_CKSUM_EN adds a trailing 32-bit
// modular-sum checksum word that must match the data words.

module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [31:0] words_written
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hdr_q, hdr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] din_q, din_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] words_q, words_d;

  logic        xfer;
  logic [31:0] hdr_nxt;
  logic [31:0] words_inc;
  logic        last_byte;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  assign in_ready  = (state_q == S_LEN) |
                     (state_q == S_DATA) |
                     (state_q == S_CKSUM);
  assign xfer      = in_valid & in_ready;
  assign hdr_nxt   = {hdr_q[23:0], in_data};
  assign words_inc = words_q + 32'd1;
  assign last_byte = (cnt_q == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    din_d   = din_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef IMEM_LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          cnt_d   = 2'd0;
          hdr_d   = 32'd0;
          words_d = 32'd0;
          addr_d  = BASE_ADDR;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d   = 32'd0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
          hdr_d = hdr_nxt;
          if (last_byte) begin
            len_d = hdr_nxt;
            if (hdr_nxt == 32'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state_d = S_CKSUM;
`else
              state_d = S_DONE;
`endif
            end else if (hdr_nxt > MAX_W) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
          din_d = {din_q[23:0], in_data};
          if (last_byte) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        addr_d  = addr_q + ADDR_STEP;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_d   = sum_q + din_q;
`endif
        if (words_inc == len_q) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
          hdr_d = hdr_nxt;
          if (last_byte) begin
            state_d = (hdr_nxt == sum_q) ? S_DONE : S_ERR;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      hdr_q   <= 32'd0;
      len_q   <= 32'd0;
      din_q   <= 32'd0;
      addr_q  <= BASE_ADDR;
      words_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  assign mem_cs        = (state_q == S_WRITE);
  assign mem_we        = (state_q == S_WRITE);
  assign mem_oe        = 1'b0;
  assign mem_addr      = addr_q;
  assign mem_din       = din_q;
  assign cpu_hold      = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream images, SRAM write capture,
// boundary headers, async reset mid-word and start/byte collision.

module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [31:0] words_written;

  int n_chk;
  int n_fail;
  int we_cnt;
  int we_base;
  logic [31:0] mem [logic [31:0]];

  imem_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_cs        (mem_cs),
    .mem_oe        (mem_oe),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model
  always @(posedge clk) begin
    if (reset_n && mem_cs && mem_we) begin
      mem[mem_addr] = mem_din;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("byte_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    send(t[31:24], gap);
    send(t[23:16], gap);
    send(t[15:8], gap);
    send(t[7:0], gap);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    we_cnt   = 0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset_n  = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_cs",   {31'd0, mem_cs},   32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst_mem_oe",   {31'd0, mem_oe},   32'd0);
    chk("rst_addr",     mem_addr,          32'h0);
    chk("rst_din",      mem_din,           32'h0);
    chk("rst_hold",     {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_words",    words_written,     32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Test 1: two-word image
    we_base = we_cnt;
    do_start();
    chk("t1_len_ready", {31'd0, in_ready}, 32'd1);
    send_word(32'h0000_0002, 0);
    send_word(32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("t1_w0_we",   {31'd0, mem_we},   32'd1);
    chk("t1_w0_cs",   {31'd0, mem_cs},   32'd1);
    chk("t1_w0_rdy",  {31'd0, in_ready}, 32'd0);
    chk("t1_w0_addr", mem_addr,          32'h0);
    chk("t1_w0_din",  mem_din,           32'hDEADBEEF);
    send_word(32'h0123_4567, 0);
    @(negedge clk);
    chk("t1_w1_we",   {31'd0, mem_we},   32'd1);
    chk("t1_w1_addr", mem_addr,          32'h4);
    chk("t1_w1_din",  mem_din,           32'h01234567);
`ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'hDFD1_0456, 0);
`endif
    @(negedge clk);
    chk("t1_done",    {31'd0, done},     32'd1);
    chk("t1_hold",    {31'd0, cpu_hold}, 32'd0);
    chk("t1_err",     {31'd0, err},      32'd0);
    chk("t1_rdy",     {31'd0, in_ready}, 32'd0);
    chk("t1_we_idle", {31'd0, mem_we},   32'd0);
    chk("t1_words",   words_written,     32'd2);
    chk("t1_addr",    mem_addr,          32'h8);
    chk("t1_nwe",     32'(we_cnt - we_base), 32'd2);
    rd = mem[32'h0];
    chk("t1_mem0", rd, 32'hDEADBEEF);
    rd = mem[32'h4];
    chk("t1_mem4", rd, 32'h01234567);

    // Test 2: same image, in_valid toggling
    we_base = we_cnt;
    mem.delete();
    do_start();
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t2_done", {31'd0, done},     32'd0);
    chk("t2_words", words_written,    32'd0);
    chk("t2_addr", mem_addr,          32'h0);
    send_word(32'h0000_0002, 1);
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h0123_4567, 1);
`ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'hDFD1_0456, 1);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("t2_done",  {31'd0, done}, 32'd1);
    chk("t2_words", words_written, 32'd2);
    chk("t2_nwe",   32'(we_cnt - we_base), 32'd2);
    rd = mem[32'h0];
    chk("t2_mem0", rd, 32'hDEADBEEF);
    rd = mem[32'h4];
    chk("t2_mem4", rd, 32'h01234567);

    // Test 3: empty image
    we_base = we_cnt;
    do_start();
    send_word(32'h0000_0000, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    @(negedge clk);
    chk("t3_cksum_wait", {31'd0, done}, 32'd0);
    send_word(32'h0000_0000, 0);
`endif
    @(negedge clk);
    chk("t3_done",  {31'd0, done},     32'd1);
    chk("t3_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("t3_words", words_written,     32'd0);
    chk("t3_nwe",   32'(we_cnt - we_base), 32'd0);

    // Test 4: oversize header
    we_base = we_cnt;
    do_start();
    send_word(32'h0000_0401, 0);
    @(negedge clk);
    chk("t4_err",  {31'd0, err},      32'd1);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t4_done", {31'd0, done},     32'd0);
    chk("t4_rdy",  {31'd0, in_ready}, 32'd0);
    chk("t4_nwe",  32'(we_cnt - we_base), 32'd0);
    do_start();
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    chk("t4_len_rdy", {31'd0, in_ready}, 32'd1);

    // Test 5: max header accepted, then reset mid-word
    we_base = we_cnt;
    send_word(32'h0000_0400, 0);
    @(negedge clk);
    chk("t5_max_ok",  {31'd0, err},      32'd0);
    chk("t5_max_rdy", {31'd0, in_ready}, 32'd1);
    send_word(32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("t5_w0_we", {31'd0, mem_we}, 32'd1);
    send(8'h01, 0);
    send(8'h23, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rdy",   {31'd0, in_ready}, 32'd0);
    chk("t5_we",    {31'd0, mem_we},   32'd0);
    chk("t5_cs",    {31'd0, mem_cs},   32'd0);
    chk("t5_addr",  mem_addr,          32'h0);
    chk("t5_din",   mem_din,           32'h0);
    chk("t5_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t5_done",  {31'd0, done},     32'd0);
    chk("t5_err",   {31'd0, err},      32'd0);
    chk("t5_words", words_written,     32'd0);
    chk("t5_nwe",   32'(we_cnt - we_base), 32'd1);
    rd = mem[32'h0];
    chk("t5_mem0", rd, 32'hCAFEF00D);
    @(negedge clk);
    reset_n = 1'b1;

    // Start coincident with a byte in IDLE: byte refused
    we_base = we_cnt;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    chk("sb_rdy", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    send_word(32'h0000_0001, 0);
    send_word(32'h1122_3344, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'h1122_3344, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("sb_done",  {31'd0, done}, 32'd1);
    chk("sb_err",   {31'd0, err},  32'd0);
    chk("sb_words", words_written, 32'd1);
    chk("sb_nwe",   32'(we_cnt - we_base), 32'd1);
    rd = mem[32'h0];
    chk("sb_mem0", rd, 32'h11223344);

`ifdef IMEM_LOADER_CKSUM_EN
    // Test 6: checksum mismatch
    do_start();
    send_word(32'h0000_0002, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0123_4567, 0);
    send_word(32'hDFD1_0457, 0);
    @(negedge clk);
    chk("t6_err",  {31'd0, err},      32'd1);
    chk("t6_done", {31'd0, done},     32'd0);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
